// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: locks to incoming VGA Hsync/Vsync, rebuilds the pixel coordinates
// and counts every sync edge that disagrees with the expected timing.
module vga_sync_decoder #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_TOTAL    = 800,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_TOTAL    = 525,
    parameter bit SYNC_POL   = 1'b0,
    parameter int LOCK_LINES = 2
) (
    input  logic        clk,
    input  logic        greset,
    input  logic        Hsync,
    input  logic        Vsync,
    output logic [14:0] Hpixel,
    output logic [14:0] Vpixel,
    output logic        activeRegion,
    output logic        locked,
    output logic        frame_start,
    output logic        sync_err,
    output logic [7:0]  err_cnt
);
    localparam logic [14:0] HSS   = 15'(H_ACTIVE + H_FP);
    localparam logic [14:0] HSE   = 15'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [14:0] VSS   = 15'(V_ACTIVE + V_FP);
    localparam logic [14:0] VSE   = 15'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [14:0] HLAST = 15'(H_TOTAL - 1);
    localparam logic [14:0] VLAST = 15'(V_TOTAL - 1);
    localparam logic [14:0] HACT  = 15'(H_ACTIVE);
    localparam logic [14:0] VACT  = 15'(V_ACTIVE);

    typedef enum logic [1:0] {SEARCH, H_ALIGN, V_WAIT, LOCKED} state_t;

    state_t      st_q, st_d;
    logic        hs_q, vs_q;
    logic [14:0] h_q, h_d, v_q, v_d, hn, vn;
    logic [7:0]  good_q, good_d, ec_q, ec_d;
    logic        fs_q, fs_d, err_q, err_d;
    logic        hs_as, hs_de, vs_as, vs_de, h_viol, v_viol, viol;

    assign Hpixel       = h_q;
    assign Vpixel       = v_q;
    assign locked       = st_q == LOCKED;
    assign activeRegion = locked && h_q < HACT && v_q < VACT;
    assign frame_start  = fs_q;
    assign sync_err     = err_q;
    assign err_cnt      = ec_q;

    always_comb begin
        hs_as  = Hsync == SYNC_POL && hs_q != SYNC_POL;
        hs_de  = Hsync != SYNC_POL && hs_q == SYNC_POL;
        vs_as  = Vsync == SYNC_POL && vs_q != SYNC_POL;
        vs_de  = Vsync != SYNC_POL && vs_q == SYNC_POL;
        hn     = h_q == HLAST ? '0 : h_q + 15'd1;
        vn     = h_q != HLAST ? v_q : v_q == VLAST ? '0 : v_q + 15'd1;
        h_d    = hs_as ? HSS : hn;
        v_d    = vs_as ? VSS : vn;
        h_viol = st_q != SEARCH && ((hs_as && hn != HSS) || (hs_de && hn != HSE));
        v_viol = st_q == LOCKED && ((vs_as && vn != VSS) || (vs_de && vn != VSE));
        viol   = h_viol || v_viol;
        err_d  = viol;
        ec_d   = viol && ec_q != 8'hff ? ec_q + 8'd1 : ec_q;
        // a Vsync reload on the wrap cycle replaces the wrap, so no frame start then
        fs_d   = st_q == LOCKED && h_q == HLAST && v_q == VLAST && !vs_as;
        st_d   = st_q;
        good_d = good_q;
        unique case (st_q)
            SEARCH: if (hs_as) begin
                st_d   = H_ALIGN;
                good_d = '0;
            end
            H_ALIGN: if (h_viol) begin
                good_d = '0;
            end else if (hs_as) begin
                good_d = good_q + 8'd1;
                if (good_d == 8'(LOCK_LINES)) st_d = V_WAIT;
            end
            V_WAIT: if (h_viol) begin
                st_d   = H_ALIGN;
                good_d = '0;
            end else if (vs_as) begin
                st_d = LOCKED;
            end
            LOCKED: if (viol) begin
                st_d   = H_ALIGN;
                good_d = '0;
            end
            default: st_d = SEARCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (greset) begin
            st_q   <= SEARCH;
            hs_q   <= ~SYNC_POL;
            vs_q   <= ~SYNC_POL;
            h_q    <= '0;
            v_q    <= '0;
            good_q <= '0;
            ec_q   <= '0;
            fs_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            hs_q   <= Hsync;
            vs_q   <= Vsync;
            h_q    <= h_d;
            v_q    <= v_d;
            good_q <= good_d;
            ec_q   <= ec_d;
            fs_q   <= fs_d;
            err_q  <= err_d;
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: feeds a scaled-down VGA stream to an active-low and an active-high
// decoder and scores coordinates, lock, frame start and error outputs against a generator model.
module tb_vga_sync_decoder;
    localparam int HA = 16, HFP = 4, HS = 6, HT = 32;
    localparam int VA = 12, VFP = 2, VS = 2, VT = 20;
    localparam int HSS = HA + HFP, VSS = VA + VFP;

    logic        clk = 1'b0, greset = 1'b1;
    logic        Hsync = 1'b1, Vsync = 1'b1, hs1 = 1'b0, vs1 = 1'b0;
    logic [14:0] hp [2];
    logic [14:0] vp [2];
    logic        act [2];
    logic        lk [2];
    logic        fs [2];
    logic        se [2];
    logic [7:0]  ec [2];

    always #5 clk = ~clk;

    vga_sync_decoder #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT), .SYNC_POL(1'b0), .LOCK_LINES(2)) u0 (
        .clk(clk), .greset(greset), .Hsync(Hsync), .Vsync(Vsync), .Hpixel(hp[0]), .Vpixel(vp[0]),
        .activeRegion(act[0]), .locked(lk[0]), .frame_start(fs[0]), .sync_err(se[0]), .err_cnt(ec[0]));

    vga_sync_decoder #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_TOTAL(VT), .SYNC_POL(1'b1), .LOCK_LINES(2)) u1 (
        .clk(clk), .greset(greset), .Hsync(hs1), .Vsync(vs1), .Hpixel(hp[1]), .Vpixel(vp[1]),
        .activeRegion(act[1]), .locked(lk[1]), .frame_start(fs[1]), .sync_err(se[1]), .err_cnt(ec[1]));

    // kind: 0 clean, 1 short line, 2 narrow Hsync, 3 early Vsync (all injected in frame 1)
    typedef struct { int kind; int line; int det_h; int det_v; int exp_h; int exp_v; } vec_t;
    typedef struct { bit chk; bit skew; int h; int v; bit lk; bit act; bit fs; bit se; int err; } exp_t;

    exp_t sb [$];
    int   checks = 0, failures = 0;
    int   gh, gv, gf, good, err_e, act_cnt;
    bit   lk_now, hs_p, vs_p, skew;

    task automatic check(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d (frame %0d line %0d col %0d)", nm, a, e, gf, gv, gh);
        end
    endtask

    task automatic compare(input exp_t e);
        for (int u = 0; u < 2; u++) begin
            if (e.chk) begin
                check($sformatf("u%0d Hpixel", u), hp[u], e.h);
                check($sformatf("u%0d Vpixel", u), vp[u], e.v);
            end
            if (!e.skew) check($sformatf("u%0d activeRegion", u), act[u], e.act);
            check($sformatf("u%0d locked", u), lk[u], e.lk);
            check($sformatf("u%0d frame_start", u), fs[u], e.fs);
            check($sformatf("u%0d sync_err", u), se[u], e.se);
            check($sformatf("u%0d err_cnt", u), ec[u], e.err);
        end
    endtask

    task automatic do_reset();
        greset = 1'b1; Hsync = 1'b1; Vsync = 1'b1; hs1 = 1'b0; vs1 = 1'b0;
        @(posedge clk); #1;
        greset = 1'b0;
        for (int u = 0; u < 2; u++) begin
            check($sformatf("u%0d reset Hpixel", u), hp[u], 0);
            check($sformatf("u%0d reset Vpixel", u), vp[u], 0);
            check($sformatf("u%0d reset locked", u), lk[u], 0);
            check($sformatf("u%0d reset activeRegion", u), act[u], 0);
            check($sformatf("u%0d reset frame_start", u), fs[u], 0);
            check($sformatf("u%0d reset sync_err", u), se[u], 0);
            check($sformatf("u%0d reset err_cnt", u), ec[u], 0);
        end
        gh = 0; gv = 0; gf = 0; good = -1; err_e = 0; act_cnt = 0;
        lk_now = 1'b0; hs_p = 1'b0; vs_p = 1'b0; skew = 1'b0;
    endtask

    task automatic tick(input vec_t t);
        exp_t e;
        bit   fault, hs_on, vs_on, det;
        int   vst, len;
        fault = gf == 1 && t.kind != 0;
        hs_on = gh >= HSS && gh < HSS + ((fault && t.kind == 2 && gv == t.line) ? HS - 1 : HS);
        vst   = (fault && t.kind == 3) ? VSS - 1 : VSS;
        vs_on = gv >= vst && gv < vst + VS;
        Hsync = !hs_on; Vsync = !vs_on; hs1 = hs_on; vs1 = vs_on;
        det   = fault && gh == t.det_h && gv == t.det_v;
        if (det) begin
            good = 0;
            err_e++;
            skew = 1'b0;
        end else if (hs_on && !hs_p && !lk_now) begin
            good++;
        end
        e.lk   = !det && (lk_now || (vs_on && !vs_p && good >= 2));
        e.skew = skew;
        e.chk  = (e.lk || det) && !skew;
        e.h    = det ? t.exp_h : gh;
        e.v    = det ? t.exp_v : gv;
        e.act  = e.lk && gh < HA && gv < VA;
        e.fs   = lk_now && gh == 0 && gv == 0;
        e.se   = det;
        e.err  = err_e;
        sb.push_back(e);
        @(posedge clk); #1;
        e = sb.pop_front();
        compare(e);
        if (gf == 1 && act[1]) act_cnt++;
        lk_now = e.lk; hs_p = hs_on; vs_p = vs_on;
        len = (fault && t.kind == 1 && gv == t.line) ? HT - 1 : HT;
        if (len != HT && gh == len - 1) skew = 1'b1;
        gh++;
        if (gh == len) begin
            gh = 0;
            gv++;
            if (gv == VT) begin
                gv = 0;
                gf++;
            end
        end
    endtask

    initial begin
        vec_t tbl [4];
        tbl[0] = '{0, 0, 0, 0, 0, 0};
        tbl[1] = '{1, 3, HSS, 4, HSS, 4};
        tbl[2] = '{2, 5, HSS + HS - 1, 5, HSS + HS - 1, 5};
        tbl[3] = '{3, 0, 0, VSS - 1, 0, VSS};
        for (int i = 0; i < 4; i++) begin
            do_reset();
            while (gf < 3) tick(tbl[i]);
            check($sformatf("scenario %0d locked at end", i), lk[0], 1);
            check($sformatf("scenario %0d err_cnt at end", i), ec[0], tbl[i].kind != 0 ? 1 : 0);
            if (tbl[i].kind == 0) check("u1 active clocks per frame", act_cnt, HA * VA);
        end
        do_reset();
        for (int k = 1; k <= 310; k++) begin
            Hsync = k[0] ? 1'b0 : 1'b1;
            hs1   = !Hsync;
            @(posedge clk); #1;
            for (int u = 0; u < 2; u++) begin
                check($sformatf("u%0d saturating err_cnt", u), ec[u], k - 1 > 255 ? 255 : k - 1);
                check($sformatf("u%0d toggling sync_err", u), se[u], k > 1 ? 1 : 0);
                check($sformatf("u%0d toggling locked", u), lk[u], 0);
            end
        end
        do_reset();
        while (gf < 2) tick(tbl[0]);
        check("relock after reset from saturation", lk[1], 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes Hsync/Vsync and reconstructs Hpixel, Vpixel and activeRegion.
- Locks to the sync edges, checks every edge against the 640x480 timing, and counts timing violations.
- Sits beside the display path as a self-check / loopback monitor. Its outputs can be compared against the generator's coordinates.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, Hsync pulse width (clocks)
H_TOTAL, 800, clocks per line
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, Vsync pulse width (lines)
V_TOTAL, 525, lines per frame
SYNC_POL, 0, asserted sync level (0 = active-low)
LOCK_LINES, 2, consecutive good Hsync falls required before vertical lock

Ports:
clk  in  1  pixel clock, same domain as the generator
greset  in  1  synchronous active-high reset
Hsync  in  1  horizontal sync, synchronous to clk
Vsync  in  1  vertical sync, synchronous to clk
Hpixel  out  15  reconstructed column
Vpixel  out  15  reconstructed row
activeRegion  out  1  locked && Hpixel<H_ACTIVE && Vpixel<V_ACTIVE
locked  out  1  high in state LOCKED
frame_start  out  1  1-cycle pulse when Vpixel wraps V_TOTAL-1 -> 0 while LOCKED
sync_err  out  1  1-cycle pulse on any timing violation
err_cnt  out  8  violation count, saturates at 255

Behaviour:
- Reset values: all outputs 0; state SEARCH; hs_q = vs_q = deasserted level; good-line count 0.
- Sync normalisation: sync is asserted when the pin equals SYNC_POL.
- Edge detection: compare the current pin with its 1-clock delayed copy (hs_q/vs_q). Edges are detected in the same cycle the pin changes. Counter outputs are registered, so they update on the next edge of clk (latency 1).
- Constants: HSS = H_ACTIVE+H_FP (656); HSE = HSS+H_SYNC (752); VSS = V_ACTIVE+V_FP (490); VSE = VSS+V_SYNC (492).
- Natural next values:
  - Hn = Hpixel+1, wrapping H_TOTAL-1 -> 0.
  - Vn = Vpixel+1 when Hpixel = H_TOTAL-1, wrapping V_TOTAL-1 -> 0; otherwise Vn = Vpixel.
- Counter updates every cycle:
  - Hpixel <= HSS on an Hsync assert edge, else Hn.
  - Vpixel <= VSS on a Vsync assert edge (this suppresses any same-cycle wrap increment), else Vn.
- Edge checks, applied only when the state is not SEARCH:
  - Hsync assert: violation if Hn != HSS.
  - Hsync deassert: violation if Hn != HSE.
- Vertical checks, applied only in LOCKED:
  - Vsync assert: violation if Vn != VSS.
  - Vsync deassert: violation if Vn != VSE.
- Multiple violations in one cycle count once.
- FSM:
  - SEARCH: Hpixel/Vpixel free-run but are meaningless. The first Hsync assert edge goes to H_ALIGN with good count 0.
  - H_ALIGN: each passing Hsync assert increments the good count. Any H violation clears it. When the count reaches LOCK_LINES, go to V_WAIT.
  - V_WAIT: an H violation returns to H_ALIGN with count 0. A Vsync assert edge goes to LOCKED; the reload itself is not checked.
  - LOCKED: any violation pulses sync_err, increments err_cnt, goes to H_ALIGN with count 0, and drops locked the next cycle.
- sync_err and err_cnt are driven only on violations in H_ALIGN, V_WAIT or LOCKED. err_cnt holds at 255 once saturated.
- Simultaneous Hsync and Vsync edges are handled independently in the same cycle.
- greset mid-frame: state returns to SEARCH and all outputs to 0 on the next clock, including err_cnt.

Test Plan:
- Reference timing stream (800x525, active-low), reset released at H=0 → locked rises 1 clk after the first Vsync fall that follows ≥2 good Hsync falls. Thereafter Hpixel/Vpixel match the generator delayed 1 clk, sync_err never pulses, and frame_start pulses once per 420000 clks.
- While locked, shorten one line to 799 clks → sync_err pulses at the next Hsync fall, err_cnt=1, locked drops. Relock completes at the following Vsync fall after 2 good lines.
- Hsync pulse width 95 instead of 96 while locked → violation at the Hsync rise (Hn=751 != 752), err_cnt increments.
- Vsync asserted at line 489 instead of 490 → violation (Vn=489), Vpixel reloads 490, state goes to H_ALIGN.
- Force 300 violations → err_cnt holds at 255. Then assert greset for 1 clk → err_cnt=0, locked=0, state SEARCH.
- SYNC_POL=1 with an inverted stream → identical lock and coordinates as the first scenario; activeRegion is high for exactly 640x480 clks per frame.
